// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter. Each stage shifts by one power of two (LSB of the amount first).
// A single advance enable freezes the whole pipe under back-pressure.
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 8,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    logic [WIDTH-1:0] r_data  [SW];
    logic [SW-1:0]    r_amt   [SW];
    logic [1:0]       r_mode  [SW];
    logic [SW-1:0]    r_valid;
    logic             w_adv;
    logic             w_unused;

    function automatic logic [WIDTH-1:0] shiftStage(
        input logic [WIDTH-1:0] data,
        input logic [1:0]       mode,
        input int               sh
    );
        logic [WIDTH-1:0] res;
        case (mode)
            MODE_SLL: res = data << sh;
            MODE_SRL: res = data >> sh;
            MODE_SRA: res = $signed(data) >>> sh;
            default:  res = (data << sh) | (data >> (WIDTH - sh));
        endcase
        return res;
    endfunction

    assign w_adv     = !r_valid[SW-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[SW-1];
    assign out_data  = r_data[SW-1];
    assign out_zero  = r_valid[SW-1] && (r_data[SW-1] == '0);

    // The last stage has no further use for amount/mode; fold them into an unused sink.
    assign w_unused = ^{r_amt[SW-1], r_mode[SW-1]};

    // The amount travels down the pipe shifted right, so every stage inspects bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < SW; k++) begin
                r_data[k] <= '0;
                r_amt[k]  <= '0;
                r_mode[k] <= '0;
            end
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            r_data[0]  <= in_amt[0] ? shiftStage(in_data, in_mode, 1) : in_data;
            r_amt[0]   <= in_amt >> 1;
            r_mode[0]  <= in_mode;
            for (int k = 1; k < SW; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_data[k]  <= r_amt[k-1][0] ? shiftStage(r_data[k-1], r_mode[k-1], 1 << k)
                                            : r_data[k-1];
                r_amt[k]   <= r_amt[k-1] >> 1;
                r_mode[k]  <= r_mode[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomised checks of pipelined_barrel_shifter (WIDTH=8) against
// hand-computed vectors and an independent whole-word shift model.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    int               vectorsApplied = 0;
    int               miscompares    = 0;
    logic [7:0]       expQ[$];
    logic [7:0]       drvExp;
    bit               lastAcc;

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Reference: whole-word shifts, rotate taken from the upper half of a doubled word.
    function automatic logic [7:0] refShift(input logic [7:0] d, input logic [2:0] a,
                                            input logic [1:0] m);
        logic [15:0] dbl;
        logic [7:0]  res;
        case (m)
            2'b00:   res = d << a;
            2'b01:   res = d >> a;
            2'b10:   res = $signed(d) >>> a;
            default: begin
                dbl = {d, d} << a;
                res = dbl[15:8];
            end
        endcase
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [2:0] a,
                                 input logic [1:0] m, input logic [7:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        drvExp   = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Scoreboard both handshakes as they stand just before the edge, then step one cycle.
    task automatic tick();
        logic [7:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious", 32'(out_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("data", 32'(out_data), 32'(e));
                checkOutput("zero", 32'(out_zero), 32'(e == 8'h00));
            end
        end
        lastAcc = in_valid && in_ready;
        if (lastAcc) expQ.push_back(drvExp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 12 && expQ.size() != 0; i++) tick();
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] opData [4];
        logic [2:0] opAmt  [4];
        logic [1:0] opMode [4];
        logic [7:0] opExp  [4];
        logic [7:0] heldData;
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] m;
        bit         wasStalled;
        int         stallCount;
        int         idx;
        int         sent;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
        out_ready = 1'b1; drvExp = '0; heldData = '0;
        #2;
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstData",  32'(out_data),  32'd0);
        checkOutput("rstZero",  32'(out_zero),  32'd0);
        checkOutput("rstReady", 32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'hB5, 3'd3, 2'b00, 8'hA8);
        tick();
        checkOutput("sllAccept", 32'(lastAcc), 32'd1);
        idle();
        checkOutput("sllLat1", 32'(out_valid), 32'd0);
        tick();
        checkOutput("sllLat2", 32'(out_valid), 32'd0);
        tick();
        checkOutput("sllLat3", 32'(out_valid), 32'd1);
        checkOutput("sllData", 32'(out_data), 32'hA8);
        drain("sllDrain");

        applyStimulus(8'hB5, 3'd3, 2'b01, 8'h16);
        tick();
        applyStimulus(8'hB5, 3'd3, 2'b10, 8'hF6);
        tick();
        applyStimulus(8'hB5, 3'd3, 2'b11, 8'hAD);
        tick();
        idle();
        checkOutput("b2bValid0", 32'(out_valid), 32'd1);
        checkOutput("b2bSrl", 32'(out_data), 32'h16);
        tick();
        checkOutput("b2bValid1", 32'(out_valid), 32'd1);
        checkOutput("b2bSra", 32'(out_data), 32'hF6);
        tick();
        checkOutput("b2bValid2", 32'(out_valid), 32'd1);
        checkOutput("b2bRol", 32'(out_data), 32'hAD);
        drain("b2bDrain");

        applyStimulus(8'h80, 3'd7, 2'b10, 8'hFF);
        tick();
        applyStimulus(8'h80, 3'd7, 2'b01, 8'h01);
        tick();
        applyStimulus(8'h01, 3'd1, 2'b01, 8'h00);
        tick();
        drain("edgeDrain");

        opData = '{8'h5A, 8'h5A, 8'hC3, 8'hC3};
        opAmt  = '{3'd1, 3'd2, 3'd4, 3'd4};
        opMode = '{2'b00, 2'b01, 2'b10, 2'b11};
        opExp  = '{8'hB4, 8'h16, 8'hFC, 8'h3C};
        idx = 0; wasStalled = 1'b0; stallCount = 0;
        for (int i = 0; i < 20; i++) begin
            out_ready = !(i >= 3 && i < 8);
            if (idx < 4) applyStimulus(opData[idx], opAmt[idx], opMode[idx], opExp[idx]);
            else idle();
            #1;
            if (out_valid && !out_ready) begin
                stallCount++;
                checkOutput("stallReady", 32'(in_ready), 32'd0);
                if (wasStalled) checkOutput("stallData", 32'(out_data), 32'(heldData));
                heldData   = out_data;
                wasStalled = 1'b1;
            end else begin
                wasStalled = 1'b0;
            end
            tick();
            if (lastAcc) idx++;
        end
        checkOutput("stallCycles", 32'(stallCount), 32'd5);
        checkOutput("streamSent", 32'(idx), 32'd4);
        drain("streamDrain");

        out_ready = 1'b1;
        applyStimulus(8'h11, 3'd1, 2'b00, 8'h22);
        tick();
        applyStimulus(8'h22, 3'd1, 2'b01, 8'h11);
        tick();
        applyStimulus(8'h33, 3'd1, 2'b11, 8'h66);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstData",  32'(out_data),  32'd0);
        checkOutput("midRstReady", 32'(in_ready),  32'd1);
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        checkOutput("postRstIdle", 32'(out_valid), 32'd0);
        applyStimulus(8'h3C, 3'd2, 2'b11, 8'hF0);
        tick();
        idle();
        tick();
        checkOutput("postRstLat2", 32'(out_valid), 32'd0);
        tick();
        checkOutput("postRstValid", 32'(out_valid), 32'd1);
        checkOutput("postRstData", 32'(out_data), 32'hF0);
        drain("postRstDrain");

        sent = 0;
        for (int c = 0; c < 40000 && sent < 10000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) begin
                d = 8'($urandom_range(0, 255));
                a = 3'($urandom_range(0, 7));
                m = 2'($urandom_range(0, 3));
                applyStimulus(d, a, m, refShift(d, a, m));
            end else begin
                idle();
            end
            tick();
            if (lastAcc) sent++;
        end
        checkOutput("randSent", 32'(sent), 32'd10000);
        drain("randDrain");

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width; legal values are powers of two, 2..64.
REQ-002 The block SHALL derive localparam SW = log2(WIDTH), giving the shift-amount width and the number of pipeline stages.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the input operand is valid.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the operand this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH, the operand.
REQ-008 The block SHALL have port in_amt, input, SW, the shift amount, 0..WIDTH-1.
REQ-009 The block SHALL have port in_mode, input, 2, the operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, WIDTH, the shifted result.
REQ-013 The block SHALL have port out_zero, output, 1, high when out_data == 0; qualified by out_valid.

Function
REQ-014 The block SHALL consist of SW registered stages; stage k (k = 0..SW-1) conditionally shifts by 2^k under control of amount bit k, LSB stage first.
REQ-015 Each stage SHALL register data, the remaining amount bits, mode and a valid bit.
REQ-016 Per stage, when amount bit k = 0 the data SHALL pass unchanged.
REQ-017 Per stage, SLL SHALL fill the vacated LSBs with 0.
REQ-018 Per stage, SRL SHALL fill the vacated MSBs with 0.
REQ-019 Per stage, SRA SHALL fill the vacated MSBs with the stage-input MSB.
REQ-020 Per stage, ROL SHALL wrap the bits shifted out at the MSB into the LSBs.
REQ-021 The pipeline SHALL be advanced by enable adv = !out_valid | out_ready; when adv = 0 every stage register SHALL hold.
REQ-022 The block SHALL drive in_ready = adv, combinationally.
REQ-023 An operand SHALL be accepted on a cycle with in_valid & in_ready.
REQ-024 When not stalled, the result SHALL appear on out_valid/out_data exactly SW cycles after acceptance.
REQ-025 With out_ready held high, throughput SHALL be one result per cycle with no bubbles inserted.
REQ-026 While out_valid & !out_ready, out_data, out_zero and out_valid SHALL remain stable.
REQ-027 When adv = 1 and in_valid = 0 (bubble), a bubble SHALL be inserted with stage valid = 0; bubble data is don't-care but must not assert out_valid.
REQ-028 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-029 in_amt = 0 SHALL return in_data unchanged for all modes.
REQ-030 SRA of an operand with MSB=1 by WIDTH-1 SHALL return all ones.
REQ-031 Results SHALL depend only on the operand's own mode and amount; a mode change between back-to-back operands shall not corrupt either.

Reset
REQ-032 While rst_n = 0, all stage valid bits and out_valid SHALL be 0 asynchronously.
REQ-033 While rst_n = 0, out_data SHALL be 0 and out_zero SHALL be 0.
REQ-034 While rst_n = 0, in_ready SHALL equal 1 (out_valid = 0).
REQ-035 Reset asserted mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear after deassertion.
REQ-036 The first operand accepted after deassertion SHALL complete with the normal SW-cycle latency.

Verification (WIDTH=8, SW=3)
REQ-037 The bench SHALL cover: 0xB5, amt 3, mode SLL, out_ready=1 -> out_data 0xA8, out_valid exactly 3 cycles after acceptance.
REQ-038 The bench SHALL cover: 0xB5, amt 3, back-to-back SRL, SRA, ROL -> 0x16, 0xF6, 0xAD on consecutive cycles, in order.
REQ-039 The bench SHALL cover: 0x80 SRA amt 7 -> 0xFF; 0x80 SRL amt 7 -> 0x01 with out_zero=0; 0x01 SRL amt 1 -> 0x00 with out_zero=1.
REQ-040 The bench SHALL cover: stream of 4 operands with out_ready low for 5 cycles mid-stream -> in_ready low while out_valid & !out_ready, out_data stable, all 4 results delivered once, in order.
REQ-041 The bench SHALL cover: rst_n pulsed low while 3 operands are in flight -> out_valid 0 immediately, no stale results, next operand 0x3C ROL amt 2 -> 0xF0 after 3 cycles.
REQ-042 The bench SHALL cover: random regression of 10,000 operands (all modes, amounts, random out_ready) against a reference model, with zero mismatches.
